diff_freq_serial_in: RTL and testbench
======================================

Name: diff_freq_serial_in

Overview:
- Receive-side counterpart of the variable-period serial transmitter. Each bit cell is slow-period or fast-period, selected per bit by a frequency pattern that both ends share.
- Samples a single-bit serial line at the midpoint of each bit cell and assembles DATA_BIT bits LSB-first into a word. Flags cells whose level is unstable.
- Used for loopback self-test and for capturing patterns from a peer in the same clock domain. Supports one-shot and repeat reception.

Parameters:
- DATA_BIT, 32: bits per frame (2..64).
- START_OFFSET, 2: clocks from the i_start cycle to the first cycle of bit 0 on i_serial_in (≥1).
- REPEAT_GAP, 1: idle clocks between the last cell of a frame and bit 0 of the next frame in repeat mode (≥0).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- i_start  in  1  arm/re-arm reception; latches mode, patterns, periods
- i_stop  in  1  abort reception, return to idle
- i_mode  in  1  0 one-shot, 1 repeat
- i_freq_pattern  in  DATA_BIT  per-bit period select, 1 = fast
- i_slow_period  in  8  slow cell length in clocks, 0 means 256
- i_fast_period  in  8  fast cell length in clocks, 0 means 256
- i_serial_in  in  1  serial line, synchronous to clk
- o_data  out  DATA_BIT  last completed frame, LSB = first bit
- o_bit_tick  out  1  one-clock pulse per bit sampled
- o_done_tick  out  1  one-clock pulse, o_data/o_err updated
- o_err  out  1  frame had ≥1 unstable cell (valid with o_done_tick, held)
- o_busy  out  1  high in any state other than S_IDLE

Behaviour:
- Reset: state S_IDLE; o_data=0; o_bit_tick=0; o_done_tick=0; o_err=0; o_busy=0; all internal buffers, counters and the shift register are 0.
- All outputs are registered. Output ticks appear one clock after the triggering event.
- Cell length P(k) = fast_period if freq_buf[k] else slow_period. A period value of 0 is treated as 256, so P uses a 9-bit internal width. Cell positions c=0..P-1 are counted with a 9-bit up-counter.
- Sample point: c == P>>1. The sampled value is shifted into the MSB of a DATA_BIT shift register (right shift), so bit 0 ends at index 0. o_bit_tick pulses one clock after the sample.
- Stability check: at c == P-1, if i_serial_in != the sampled value, set the sticky err_acc.
- States:
  - S_IDLE: wait for i_start.
  - S_WAIT: count gap clocks; then go to S_RECV with k=0, c=0.
  - S_RECV: step through the cells.
  - S_DONE: one clock.
- i_start (any state, including S_RECV/S_WAIT): latch i_mode, i_freq_pattern, i_slow_period, i_fast_period. Clear the shift register, err_acc and k. Enter S_WAIT with gap = START_OFFSET-1. The cycle at which i_start is high counts as clock 0.
- i_stop takes priority over i_start and cell processing. It sends the block to S_IDLE with no o_done_tick; o_data and o_err are unchanged.
- S_RECV, c == P(k)-1:
  - If k == DATA_BIT-1, go to S_DONE.
  - Otherwise k++ and c=0, with the next P taken from freq_buf[k+1].
- S_DONE:
  - o_data <= shift register (including the final sample); o_err <= err_acc; o_done_tick pulses.
  - If mode is repeat: clear err_acc and go to S_WAIT with gap = REPEAT_GAP, or directly to S_RECV if REPEAT_GAP = 0.
  - Otherwise go to S_IDLE.
- Because of REPEAT_GAP timing, S_DONE occupies the first gap clock.
- Latched configuration is not affected by input changes until the next i_start.
- o_err does not change between done ticks.

Test Plan:
- One-shot, all slow: slow=9, pattern 0, data 0xA5A5_0F0F, i_start at t0 → 32 bit ticks, each 9 clocks apart. o_done_tick at t0+2+288. o_data=0xA5A50F0F, o_err=0.
- Mixed periods: slow=9, fast=3, freq=0x0000FFFF, data 0x1234_5678 → bits 0-15 sampled every 3 clocks and bits 16-31 every 9. o_data=0x12345678.
- Repeat mode: two frames 0xDEADBEEF, then 0x0, REPEAT_GAP=1 → done ticks separated by 32·P+1 clocks. Second o_data=0x00000000.
- Glitch: toggle i_serial_in at c=P-1 of bit 5 → o_err=1 at done. The next clean repeat frame gives o_err=0.
- i_stop at bit 10 → no done tick, o_busy=0 next clock, o_data keeps its previous value. A following i_start receives correctly.
- Period 0 and restart: slow=0 → 256-clock cells, sampled at c=128. An i_start issued mid-frame restarts the timing from the new START_OFFSET with no stale bits.

Source files
------------

// File: rtl/diff_freq_serial_in.sv
// Variable-period serial receiver: samples each bit cell at its midpoint and
// assembles DATA_BIT bits LSB-first; flags cells whose level moves before the cell ends.
module diff_freq_serial_in #(
   parameter int DATA_BIT     = 32,
   parameter int START_OFFSET = 2,
   parameter int REPEAT_GAP   = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_start,
   input  logic                i_stop,
   input  logic                i_mode,
   input  logic [DATA_BIT-1:0] i_freq_pattern,
   input  logic [7:0]          i_slow_period,
   input  logic [7:0]          i_fast_period,
   input  logic                i_serial_in,
   output logic [DATA_BIT-1:0] o_data,
   output logic                o_bit_tick,
   output logic                o_done_tick,
   output logic                o_err,
   output logic                o_busy
);

   localparam int KW = (DATA_BIT > 2) ? $clog2(DATA_BIT) : 1;
   // S_DONE already accounts for one idle clock between repeated frames.
   localparam int START_WAIT = START_OFFSET - 1;
   localparam int REP_WAIT   = (REPEAT_GAP > 1) ? REPEAT_GAP - 1 : 0;
   localparam logic [KW-1:0] K_LAST = KW'(DATA_BIT - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RECV, S_DONE} state_t;

   state_t              state;
   logic                mode;
   logic [DATA_BIT-1:0] freq_buf;
   logic [DATA_BIT-1:0] shreg;
   logic [7:0]          slow_buf;
   logic [7:0]          fast_buf;
   logic [8:0]          cnt;
   logic [15:0]         gap;
   logic [KW-1:0]       k;
   logic                err_acc;
   logic                samp;

   logic [7:0]          per_sel;
   logic [8:0]          cell_len;
   logic                at_sample;
   logic                at_end;
   logic                ref_bit;
   logic                mism;
   logic [DATA_BIT-1:0] shreg_next;

   // Current cell geometry and the stability comparison for this clock.
   always_comb begin
      per_sel    = freq_buf[k] ? fast_buf : slow_buf;
      cell_len   = (per_sel == 8'd0) ? 9'd256 : {1'b0, per_sel};
      at_sample  = (cnt == (cell_len >> 1));
      at_end     = (cnt == (cell_len - 9'd1));
      ref_bit    = at_sample ? i_serial_in : samp;
      mism       = at_end && (i_serial_in != ref_bit);
      shreg_next = {i_serial_in, shreg[DATA_BIT-1:1]};
   end

   // Receive FSM with registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         mode        <= 1'b0;
         freq_buf    <= '0;
         shreg       <= '0;
         slow_buf    <= 8'd0;
         fast_buf    <= 8'd0;
         cnt         <= 9'd0;
         gap         <= 16'd0;
         k           <= '0;
         err_acc     <= 1'b0;
         samp        <= 1'b0;
         o_data      <= '0;
         o_bit_tick  <= 1'b0;
         o_done_tick <= 1'b0;
         o_err       <= 1'b0;
         o_busy      <= 1'b0;
      end else if (i_stop) begin
         state       <= S_IDLE;
         o_bit_tick  <= 1'b0;
         o_done_tick <= 1'b0;
         o_busy      <= 1'b0;
      end else if (i_start) begin
         mode        <= i_mode;
         freq_buf    <= i_freq_pattern;
         slow_buf    <= i_slow_period;
         fast_buf    <= i_fast_period;
         shreg       <= '0;
         err_acc     <= 1'b0;
         k           <= '0;
         cnt         <= 9'd0;
         o_bit_tick  <= 1'b0;
         o_done_tick <= 1'b0;
         o_busy      <= 1'b1;
         if (START_WAIT == 0) begin
            state <= S_RECV;
         end else begin
            state <= S_WAIT;
            gap   <= 16'(START_WAIT);
         end
      end else begin
         case (state)
            S_IDLE: begin
               o_bit_tick  <= 1'b0;
               o_done_tick <= 1'b0;
               o_busy      <= 1'b0;
            end
            S_WAIT: begin
               o_bit_tick  <= 1'b0;
               o_done_tick <= 1'b0;
               o_busy      <= 1'b1;
               if (gap <= 16'd1) begin
                  state <= S_RECV;
                  cnt   <= 9'd0;
                  k     <= '0;
               end else begin
                  gap <= gap - 16'd1;
               end
            end
            S_RECV: begin
               o_bit_tick <= at_sample;
               o_busy     <= 1'b1;
               if (at_sample) begin
                  shreg <= shreg_next;
                  samp  <= i_serial_in;
               end
               if (mism) begin
                  err_acc <= 1'b1;
               end
               // The last cell's sample may land on its final clock, so take shreg_next.
               if (at_end && (k == K_LAST)) begin
                  state       <= S_DONE;
                  o_data      <= at_sample ? shreg_next : shreg;
                  o_err       <= err_acc | mism;
                  o_done_tick <= 1'b1;
               end else if (at_end) begin
                  k           <= k + 1'b1;
                  cnt         <= 9'd0;
                  o_done_tick <= 1'b0;
               end else begin
                  cnt         <= cnt + 9'd1;
                  o_done_tick <= 1'b0;
               end
            end
            S_DONE: begin
               o_bit_tick  <= 1'b0;
               o_done_tick <= 1'b0;
               if (mode) begin
                  err_acc <= 1'b0;
                  k       <= '0;
                  cnt     <= 9'd0;
                  o_busy  <= 1'b1;
                  if (REP_WAIT == 0) begin
                     state <= S_RECV;
                  end else begin
                     state <= S_WAIT;
                     gap   <= 16'(REP_WAIT);
                  end
               end else begin
                  state  <= S_IDLE;
                  o_busy <= 1'b0;
               end
            end
            default: begin
               state       <= S_IDLE;
               o_bit_tick  <= 1'b0;
               o_done_tick <= 1'b0;
               o_busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_diff_freq_serial_in.sv
// Bench for diff_freq_serial_in: a per-cycle timeline of stimulus and expected
// outputs is built arithmetically from frame descriptions, then replayed and compared.
module tb_diff_freq_serial_in;

   localparam int N  = 10100;
   localparam int SO = 2;
   localparam int RG = 1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_start = 1'b0;
   logic        i_stop = 1'b0;
   logic        i_mode = 1'b0;
   logic [31:0] i_freq_pattern = 32'd0;
   logic [7:0]  i_slow_period = 8'd0;
   logic [7:0]  i_fast_period = 8'd0;
   logic        i_serial_in = 1'b0;
   logic [31:0] o_data;
   logic        o_bit_tick;
   logic        o_done_tick;
   logic        o_err;
   logic        o_busy;

   diff_freq_serial_in #(.DATA_BIT(32), .START_OFFSET(SO), .REPEAT_GAP(RG)) dut (
      .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_stop(i_stop), .i_mode(i_mode),
      .i_freq_pattern(i_freq_pattern), .i_slow_period(i_slow_period),
      .i_fast_period(i_fast_period), .i_serial_in(i_serial_in), .o_data(o_data),
      .o_bit_tick(o_bit_tick), .o_done_tick(o_done_tick), .o_err(o_err), .o_busy(o_busy)
   );

   always #5 clk = ~clk;

   // Stimulus timeline (index = cycle whose rising edge samples it).
   logic        ser_a   [N];
   logic        start_a [N];
   logic        stop_a  [N];
   logic        mode_a  [N];
   logic [31:0] pat_a   [N];
   logic [7:0]  slow_a  [N];
   logic [7:0]  fast_a  [N];
   // Expected outputs (index = cycle in which the value is visible).
   logic        exp_bt   [N];
   logic        exp_dt   [N];
   logic        exp_busy [N];
   logic        exp_err  [N];
   logic [31:0] exp_data [N];

   int cyc = 0;
   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
      end
   endtask

   // Describe a reception: cells are laid end to end from t0+START_OFFSET; each
   // cell shows the inverted bit before its midpoint and the true bit from it on.
   // Everything at or after 'cut' (a stop or a restart) never happens.
   task automatic run_rx(input int t0, input bit md, input int nfr,
                         input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] pat, input int slow, input int fast,
                         input int gl_frame, input int gl_bit, input int cut);
      int t, p, half, busy_end;
      logic [31:0] d;
      logic err;
      start_a[t0] = 1'b1;
      mode_a[t0]  = md;
      pat_a[t0]   = pat;
      slow_a[t0]  = 8'(slow);
      fast_a[t0]  = 8'(fast);
      t = t0 + SO;
      busy_end = cut;
      for (int f = 0; f < nfr; f++) begin
         d = (f == 0) ? d0 : ((f == 1) ? d1 : d2);
         err = 1'b0;
         for (int b = 0; b < 32; b++) begin
            p = pat[b] ? fast : slow;
            if (p == 0) p = 256;
            half = p / 2;
            for (int c = 0; c < p; c++)
               if (t + c < cut) ser_a[t + c] = (c < half) ? ~d[b] : d[b];
            if (f == gl_frame && b == gl_bit) begin
               if (t + p - 1 < cut) ser_a[t + p - 1] = ~d[b];
               err = 1'b1;
            end
            if (t + half < cut) exp_bt[t + half + 1] = 1'b1;
            t += p;
         end
         if (t - 1 < cut) begin
            exp_dt[t] = 1'b1;
            for (int v = t; v < N; v++) begin
               exp_data[v] = d;
               exp_err[v]  = err;
            end
            if (!md && t < busy_end) busy_end = t;
         end
         t += (RG > 1) ? RG : 1;
      end
      for (int v = t0 + 1; v <= busy_end && v < N; v++) exp_busy[v] = 1'b1;
   endtask

   // Driver: build the timeline, then replay it cycle by cycle.
   initial begin
      for (int n = 0; n < N; n++) begin
         ser_a[n] = 1'b0; start_a[n] = 1'b0; stop_a[n] = 1'b0;
         mode_a[n] = 1'($urandom); pat_a[n] = $urandom;
         slow_a[n] = 8'($urandom); fast_a[n] = 8'($urandom);
         exp_bt[n] = 1'b0; exp_dt[n] = 1'b0; exp_busy[n] = 1'b0;
         exp_err[n] = 1'b0; exp_data[n] = 32'd0;
      end
      // one-shot, all slow
      run_rx(5, 1'b0, 1, 32'hA5A5_0F0F, 32'd0, 32'd0, 32'h0000_0000, 9, 0, -1, -1, N);
      // mixed periods
      run_rx(300, 1'b0, 1, 32'h1234_5678, 32'd0, 32'd0, 32'h0000_FFFF, 9, 3, -1, -1, N);
      // repeat: two full frames then stopped inside the third
      run_rx(500, 1'b1, 3, 32'hDEAD_BEEF, 32'h0000_0000, 32'h0000_0000, 32'h0, 7, 0, -1, -1, 960);
      stop_a[960] = 1'b1;
      // repeat with a glitch in bit 5 of the first frame
      run_rx(1000, 1'b1, 3, 32'h0F0F_00FF, 32'h55AA_55AA, 32'hFFFF_0000, 32'h0, 9, 0, 0, 5, 1585);
      stop_a[1585] = 1'b1;
      // stop during bit 10, then a clean reception
      run_rx(1600, 1'b0, 1, 32'hCAFE_F00D, 32'd0, 32'd0, 32'h0, 9, 0, -1, -1, 1695);
      stop_a[1695] = 1'b1;
      run_rx(1700, 1'b0, 1, 32'h1357_9BDF, 32'd0, 32'd0, 32'hAAAA_5555, 5, 2, -1, -1, N);
      // restart mid-frame into 256-clock cells
      run_rx(1830, 1'b0, 1, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'h0, 4, 0, -1, -1, 1862);
      run_rx(1862, 1'b0, 1, 32'h8000_0001, 32'd0, 32'd0, 32'h0, 0, 0, -1, -1, N);

      for (int n = 0; n < N; n++) begin
         rst_n          = (n >= 2);
         i_start        = start_a[n];
         i_stop         = stop_a[n];
         i_mode         = mode_a[n];
         i_freq_pattern = pat_a[n];
         i_slow_period  = slow_a[n];
         i_fast_period  = fast_a[n];
         i_serial_in    = ser_a[n];
         @(posedge clk);
         #1;
         cyc = n + 1;
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Compare process: timeline model every cycle, plus hand-computed pins.
   always @(negedge clk) begin
      if (cyc >= 1 && cyc < N) begin
         check("bit_tick", 32'(o_bit_tick), 32'(exp_bt[cyc]));
         check("done_tick", 32'(o_done_tick), 32'(exp_dt[cyc]));
         check("busy", 32'(o_busy), 32'(exp_busy[cyc]));
         check("err", 32'(o_err), 32'(exp_err[cyc]));
         check("data", o_data, exp_data[cyc]);
         case (cyc)
            2:     check("reset_busy", 32'(o_busy), 32'd0);
            12:    check("s1_first_tick", 32'(o_bit_tick), 32'd1);
            295: begin
               check("s1_done", 32'(o_done_tick), 32'd1);
               check("s1_data", o_data, 32'hA5A5_0F0F);
            end
            494:   check("mixed_data", o_data, 32'h1234_5678);
            726:   check("rep_data1", o_data, 32'hDEAD_BEEF);
            951: begin
               check("rep_done2", 32'(o_done_tick), 32'd1);
               check("rep_data2", o_data, 32'h0000_0000);
            end
            1290:  check("glitch_err", 32'(o_err), 32'd1);
            1579:  check("clean_err", 32'(o_err), 32'd0);
            1696: begin
               check("stop_busy", 32'(o_busy), 32'd0);
               check("stop_data", o_data, 32'h55AA_55AA);
            end
            1814:  check("after_stop_data", o_data, 32'h1357_9BDF);
            10056: check("p256_data", o_data, 32'h8000_0001);
            default: ;
         endcase
      end
   end

endmodule
